// File: rtl/btn_charge_meter.sv
// Button squeeze meter: synchronizes and debounces the player button, then charges
// a squeeze level while held and fires a launch velocity on release. Optional macro: CHARGE_AUTO_RELEASE_EN.
module btn_charge_meter #(
    parameter int unsigned DEBOUNCE_CYCLES  = 250000,
    parameter int unsigned STEP_CYCLES      = 1000000,
    parameter int unsigned V_BASE           = 16,
    parameter int unsigned V_STEP           = 8,
    parameter int unsigned AUTO_HOLD_CYCLES = 25000000
) (
    input  logic        clk_machine,
    input  logic        rst_machine,
    input  logic        i_btn,
    input  logic        i_arm,
    output logic        o_btn_db,
    output logic        o_charging,
    output logic [3:0]  o_squeeze,
    output logic [10:0] o_v_init,
    output logic        o_fire
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned STEP_W  = $clog2(STEP_CYCLES + 1);
    localparam int unsigned SQ_W    = 4;
    localparam int unsigned V_W     = 11;
    localparam int unsigned SUM_W   = 12;
    localparam logic [SQ_W-1:0] SQ_MAX = SQ_W'(14);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHARGE   = 2'd1,
        S_FIRE     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    logic              sync1, sync2, db_prev;
    logic [DB_W-1:0]   db_cnt;
    logic              db_rise_c, db_fall_c;

    state_t            state, state_n;
    logic [STEP_W-1:0] step_cnt, step_n;
    logic [SQ_W-1:0]   squeeze_n;
    logic [V_W-1:0]    v_init_n;
    logic              fire_n, charging_n;
    logic [SUM_W-1:0]  v_sum_c;
    logic [V_W-1:0]    v_clip_c;
    logic              hold_done_c;

    // Two-flop synchronizer followed by a consecutive-cycle debounce counter
    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            o_btn_db <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1   <= i_btn;
            sync2   <= sync1;
            db_prev <= o_btn_db;
            if (sync2 != o_btn_db) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    o_btn_db <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign db_rise_c = o_btn_db & ~db_prev;
    assign db_fall_c = ~o_btn_db & db_prev;

    // Launch velocity, clipped to the 11-bit output range
    assign v_sum_c  = SUM_W'(V_BASE) + SUM_W'(o_squeeze) * SUM_W'(V_STEP);
    assign v_clip_c = (v_sum_c > SUM_W'(2047)) ? {V_W{1'b1}} : v_sum_c[V_W-1:0];

`ifdef CHARGE_AUTO_RELEASE_EN
    localparam int unsigned HOLD_W = $clog2(AUTO_HOLD_CYCLES + 1);

    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              auto_fired, auto_n;

    assign hold_done_c = (o_squeeze == SQ_MAX) && (hold_cnt == HOLD_W'(AUTO_HOLD_CYCLES - 1));

    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            hold_cnt   <= '0;
            auto_fired <= 1'b0;
        end else begin
            hold_cnt   <= hold_n;
            auto_fired <= auto_n;
        end
    end
`else
    logic [31:0] unused_hold;

    // Auto-release compiled out: the hold time has no effect on this build
    assign unused_hold = 32'(AUTO_HOLD_CYCLES);
    assign hold_done_c = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk_machine) begin
        if (rst_machine) begin
            state      <= S_IDLE;
            step_cnt   <= '0;
            o_squeeze  <= '0;
            o_v_init   <= '0;
            o_fire     <= 1'b0;
            o_charging <= 1'b0;
        end else begin
            state      <= state_n;
            step_cnt   <= step_n;
            o_squeeze  <= squeeze_n;
            o_v_init   <= v_init_n;
            o_fire     <= fire_n;
            o_charging <= charging_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        step_n    = step_cnt;
        squeeze_n = o_squeeze;
        v_init_n  = o_v_init;
        fire_n    = 1'b0;
`ifdef CHARGE_AUTO_RELEASE_EN
        hold_n    = hold_cnt;
        auto_n    = auto_fired;
`endif
        case (state)
            S_IDLE: begin
                step_n    = '0;
                squeeze_n = '0;
`ifdef CHARGE_AUTO_RELEASE_EN
                hold_n    = '0;
                auto_n    = 1'b0;
`endif
                if (db_rise_c) begin
                    state_n = i_arm ? S_CHARGE : S_WAIT_REL;
                end
            end
            S_CHARGE: begin
                if (!i_arm) begin
                    // Abort outranks a release landing on the same cycle
                    state_n   = o_btn_db ? S_WAIT_REL : S_IDLE;
                    squeeze_n = '0;
                    step_n    = '0;
`ifdef CHARGE_AUTO_RELEASE_EN
                    hold_n    = '0;
`endif
                end else if (db_fall_c || hold_done_c) begin
                    state_n  = S_FIRE;
                    fire_n   = 1'b1;
                    v_init_n = v_clip_c;
`ifdef CHARGE_AUTO_RELEASE_EN
                    auto_n   = ~db_fall_c;
`endif
                end else begin
                    if (step_cnt == STEP_W'(STEP_CYCLES - 1)) begin
                        step_n = '0;
                        if (o_squeeze != SQ_MAX) begin
                            squeeze_n = o_squeeze + SQ_W'(1);
                        end
                    end else begin
                        step_n = step_cnt + STEP_W'(1);
                    end
`ifdef CHARGE_AUTO_RELEASE_EN
                    hold_n = (o_squeeze == SQ_MAX) ? hold_cnt + HOLD_W'(1) : '0;
`endif
                end
            end
            S_FIRE: begin
                squeeze_n = '0;
                step_n    = '0;
`ifdef CHARGE_AUTO_RELEASE_EN
                hold_n    = '0;
                auto_n    = 1'b0;
                state_n   = auto_fired ? S_WAIT_REL : S_IDLE;
`else
                state_n   = S_IDLE;
`endif
            end
            S_WAIT_REL: begin
                if (!o_btn_db) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        charging_n = (state_n == S_CHARGE);
    end

endmodule

// File: doc/btn_charge_meter.md
BTN_CHARGE_METER -- requirements
Module: btn_charge_meter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable synchronized-input cycles required to accept a button level change.
REQ-002 Parameter STEP_CYCLES, default 1000000: CHARGE cycles per squeeze level increment.
REQ-003 Parameter V_BASE, default 16: launch velocity at squeeze 0.
REQ-004 Parameter V_STEP, default 8: launch velocity added per squeeze level.
REQ-005 Parameter AUTO_HOLD_CYCLES, default 25000000: saturated-hold time before auto-fire, used only under the macro in REQ-025.
REQ-006 clk_machine  in  1  single clock, 25.175 MHz; one clock only.
REQ-007 rst_machine  in  1  reset, synchronous, active-high.
REQ-008 i_btn  in  1  raw player button, asynchronous, active-high.
REQ-009 i_arm  in  1  game FSM ready to accept a charge (FSM in its wait-for-press state).
REQ-010 o_btn_db  out  1  debounced button level.
REQ-011 o_charging  out  1  high while in CHARGE.
REQ-012 o_squeeze  out  4  current squeeze level 0..14, driven to the FSM squeeze/graphics path.
REQ-013 o_v_init  out  11  launch velocity latched at fire.
REQ-014 o_fire  out  1  single-cycle pulse: charge complete, o_v_init valid this cycle.

Function
REQ-015 i_btn SHALL pass a 2-flop synchronizer; o_btn_db SHALL take the synchronized value once it has differed from o_btn_db for DEBOUNCE_CYCLES consecutive cycles; any reversal clears the count.
REQ-016 The FSM SHALL have states IDLE, CHARGE, FIRE, WAIT_RELEASE, encoded in 2 bits.
REQ-017 IDLE: on an o_btn_db rising edge with i_arm=1, go to CHARGE with o_squeeze=0 and the step counter at 0; a rising edge with i_arm=0 SHALL go to WAIT_RELEASE.
REQ-018 CHARGE: the step counter SHALL count 0..STEP_CYCLES-1 and wrap; on each wrap o_squeeze SHALL increment, saturating at 14.
REQ-019 CHARGE: an o_btn_db falling edge SHALL go to FIRE.
REQ-020 CHARGE: i_arm=0 SHALL abort to WAIT_RELEASE (if o_btn_db=1) or IDLE (if 0), with o_squeeze=0 and no o_fire; abort has priority over a simultaneous falling edge.
REQ-021 FIRE, exactly one cycle: o_fire=1; o_v_init=min(V_BASE+o_squeeze*V_STEP, 2047) using a 12-bit intermediate; next state IDLE with o_squeeze=0; o_v_init SHALL hold until the next fire.
REQ-022 WAIT_RELEASE: go to IDLE when o_btn_db=0; a button already held when i_arm rises SHALL NOT start a charge.
REQ-023 Latency: o_fire SHALL assert exactly 1 cycle after o_btn_db falls; o_btn_db SHALL change DEBOUNCE_CYCLES+2 cycles after a stable raw change.

Reset
REQ-024 While rst_machine=1 at a clock edge: state IDLE; synchronizer flops, o_btn_db, o_charging, o_squeeze, o_v_init, o_fire, and all counters 0; reset mid-charge SHALL discard the charge without o_fire.

Configuration
REQ-025 Macro CHARGE_AUTO_RELEASE_EN, when defined: if o_squeeze=14 for AUTO_HOLD_CYCLES consecutive CHARGE cycles, go to FIRE (o_v_init=V_BASE+14*V_STEP), then WAIT_RELEASE instead of IDLE. When undefined: no timer logic; CHARGE is held indefinitely at 14.

Verification (DEBOUNCE_CYCLES=4, STEP_CYCLES=10, V_BASE=16, V_STEP=8, AUTO_HOLD_CYCLES=50)
REQ-026 Reset, i_arm=1, o_btn_db high for 35 cycles then release -> o_squeeze steps 1,2,3 at 10-cycle spacing; one o_fire 1 cycle after o_btn_db falls; o_v_init=40.
REQ-027 i_btn 3-cycle glitch high -> o_btn_db stays 0; o_charging stays 0; no o_fire.
REQ-028 Hold 200 cycles, macro undefined -> o_squeeze saturates at 14; release gives o_v_init=128.
REQ-029 i_arm drops at o_squeeze=5 -> o_squeeze=0, no o_fire. Button held as i_arm rises -> no charge until release and re-press.
REQ-030 Macro defined, hold 14+ levels -> after 50 cycles at 14, o_fire with o_v_init=128; later release -> no second o_fire.
REQ-031 rst_machine pulsed during CHARGE at o_squeeze=7 -> all outputs 0 next cycle; o_v_init=0; no o_fire.
